// File: rtl/seq_gates_debounce_pkg.sv
// Shared types and constants for the 1-bit debouncer.
// Holds the FSM state encoding and the accepted-change count width.
package seq_gates_debounce_pkg;

    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] v
    );
        return (v == COUNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/seq_gates_sync2.sv
// Two-flop synchronizer for the raw debouncer input.
// Both flops clear asynchronously on reset.
module seq_gates_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= in;
            r_ff2 <= r_ff1;
        end
    end

    assign out = r_ff2;

endmodule

// File: rtl/seq_gates_1b_debounce.sv
// 1-bit debouncer feeding a downstream DFFE (en/d) with change counter.
// Define SEQ_GATES_DEBOUNCE_SYNC_EN to insert a 2-flop input synchronizer.
module seq_gates_1b_debounce
    import seq_gates_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               raw,
    input  logic               clear,
    output logic               en,
    output logic               d,
    output logic               pending,
    output logic [COUNT_W-1:0] count
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    generate
        if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad
            $error("STABLE_CYCLES must be in 2..255");
        end
    endgenerate

    logic w_s;

`ifdef SEQ_GATES_DEBOUNCE_SYNC_EN
    seq_gates_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .in    (raw),
        .out   (w_s)
    );
`else
    assign w_s = raw;
`endif

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_d;
    logic               r_en;
    logic [COUNT_W-1:0] r_count;
    logic               w_accept;

    // Candidate survives its final qualifying sample this edge.
    assign w_accept = (r_cnt == LAST) &&
                      (((r_state == PEND_HI) &&  w_s) ||
                       ((r_state == PEND_LO) && !w_s));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_en    <= 1'b0;
            r_count <= '0;
        end else begin
            r_en <= 1'b0;
            unique case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= PEND_HI;
                        r_cnt   <= ONE;
                    end
                end
                PEND_HI: begin
                    if (!w_s) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= STABLE_HI;
                        r_d     <= 1'b1;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= PEND_LO;
                        r_cnt   <= ONE;
                    end
                end
                PEND_LO: begin
                    if (w_s) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST) begin
                        r_state <= STABLE_LO;
                        r_d     <= 1'b0;
                        r_en    <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase

            // Clear wins, but a same-edge acceptance still counts once.
            if (clear) begin
                r_count <= w_accept ? COUNT_W'(1) : '0;
            end else if (w_accept) begin
                r_count <= sat_inc(r_count);
            end
        end
    end

    assign en      = r_en;
    assign d       = r_d;
    assign count   = r_count;
    assign pending = (r_state == PEND_HI) || (r_state == PEND_LO);

endmodule

// File: tb/tb_seq_gates_1b_debounce.sv
// Randomized bench for seq_gates_1b_debounce against a run-length model.
// Also chains a 1b DFFE on en/d and checks it tracks the model.
`timescale 1ns/1ps
module tb_seq_gates_1b_debounce;

    localparam int N = 4;
`ifdef SEQ_GATES_DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       raw;
    logic       clear;
    logic       en;
    logic       d;
    logic       pending;
    logic [7:0] count;
    logic       q;

    always #5 clk = ~clk;

    seq_gates_1b_debounce #(.STABLE_CYCLES(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .raw     (raw),
        .clear   (clear),
        .en      (en),
        .d       (d),
        .pending (pending),
        .count   (count)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) q <= 1'b0;
        else if (en) q <= d;
    end

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_run;
    int   m_cnt;
    logic m_d;
    logic m_en;
    logic m_q;
    logic m_pipe [2];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0;
        m_cnt = 0;
        m_d = 1'b0;
        m_en = 1'b0;
        m_q = 1'b0;
        m_pipe[0] = 1'b0;
        m_pipe[1] = 1'b0;
    endtask

    // Level flips after N consecutive samples differing from it.
    task automatic model_step(input logic r, input logic c);
        logic s;
        if (m_en) m_q = m_d;
`ifdef SEQ_GATES_DEBOUNCE_SYNC_EN
        s = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = r;
`else
        s = r;
`endif
        m_en = 1'b0;
        if (s != m_d) begin
            m_run++;
            if (m_run == N) begin
                m_d = s;
                m_en = 1'b1;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (c) m_cnt = m_en ? 1 : 0;
        else if (m_en && m_cnt < 255) m_cnt++;
    endtask

    task automatic compare_all();
        check("d", 32'(d), 32'(m_d));
        check("en", 32'(en), 32'(m_en));
        check("pending", 32'(pending), 32'(m_run > 0));
        check("count", 32'(count), 32'(m_cnt));
        check("dffe_q", 32'(q), 32'(m_q));
    endtask

    task automatic step(input logic r, input logic c);
        raw = r;
        clear = c;
        @(posedge clk);
        model_step(r, c);
        #1;
        compare_all();
    endtask

    // raw held high from a stable-low start: strobe after N+LAT edges.
    task automatic qualify_rise(input string tag);
        for (int i = 1; i <= N + LAT + 1; i++) begin
            step(1'b1, 1'b0);
            check({tag, "_en"}, 32'(en), 32'(i == N + LAT));
            check({tag, "_d"}, 32'(d), 32'(i >= N + LAT));
            if (i == LAT + 1)
                check({tag, "_pend"}, 32'(pending), 32'd1);
        end
    endtask

    initial begin
        int   ens;
        logic lv;
        logic q0;
        raw = 1'b0;
        clear = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_d", 32'(d), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        qualify_rise("rise");
        check("rise_count", 32'(count), 32'd1);

        for (int i = 0; i < N + LAT + 1; i++) step(1'b0, 1'b0);
        check("fall_d", 32'(d), 32'd0);
        check("fall_count", 32'(count), 32'd2);

        ens = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            ens += int'(en);
        end
        for (int i = 0; i < LAT + 1; i++) begin
            step(1'b0, 1'b0);
            ens += int'(en);
        end
        check("short_en", 32'(ens), 32'd0);
        check("short_pend", 32'(pending), 32'd0);
        check("short_d", 32'(d), 32'd0);
        check("short_count", 32'(count), 32'd2);

        for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0);
        check("pre_rst_pend", 32'(pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_d", 32'(d), 32'd0);
        check("arst_en", 32'(en), 32'd0);
        check("arst_pend", 32'(pending), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        qualify_rise("fresh");

        for (int k = 0; k < 300; k++) begin
            lv = !m_d;
            for (int i = 0; i < N + LAT; i++) step(lv, 1'b0);
        end
        check("sat_count", 32'(count), 32'd255);
        lv = !m_d;
        for (int i = 0; i < N + LAT; i++)
            step(lv, i == N + LAT - 1);
        check("clr_acc_en", 32'(en), 32'd1);
        check("clr_acc_count", 32'(count), 32'd1);

        for (int i = 0; i < N + LAT; i++) step(m_d, 1'b0);
        q0 = m_q;
        for (int k = 0; k < 5; k++) begin
            lv = m_d;
            for (int i = 0; i < 3; i++) step(!lv, 1'b0);
            for (int i = 0; i < 3; i++) step(lv, 1'b0);
        end
        check("pulse_q", 32'(q), 32'(q0));

        for (int k = 0; k < 600; k++) begin
            lv = 1'($urandom_range(0, 1));
            for (int i = 0; i < int'($urandom_range(1, N + 2)); i++)
                step(lv, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_gates_1b_debounce.md
SEQ_GATES_1B_DEBOUNCE -- requirements
Module: seq_gates_1b_debounce

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, default 4, number of consecutive equal samples required to accept a new level (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: raw  input  1  undebounced input level.
REQ-005 SHALL have port: clear  input  1  synchronous clear of count.
REQ-006 SHALL have port: en  output  1  one-cycle strobe on an accepted level change; feeds downstream 1b DFFE enable.
REQ-007 SHALL have port: d  output  1  debounced level; feeds downstream 1b DFFE data.
REQ-008 SHALL have port: pending  output  1  high while a candidate change is being qualified.
REQ-009 SHALL have port: count  output  8  saturating count of accepted changes.

Function
REQ-010 SHALL define sampled input s as raw, or the synchronizer output when REQ-024 applies.
REQ-011 SHALL implement a four-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-012 In STABLE_LO with s=1, the FSM SHALL go to PEND_HI with cnt=1; otherwise it SHALL stay.
REQ-013 In PEND_HI, s=0 SHALL return the FSM to STABLE_LO with cnt=0 and no strobe.
REQ-014 In PEND_HI, s=1 with cnt<STABLE_CYCLES-1 SHALL increment cnt.
REQ-015 In PEND_HI, s=1 with cnt=STABLE_CYCLES-1 SHALL go to STABLE_HI, set d=1, pulse en and clear cnt.
REQ-016 STABLE_HI and PEND_LO SHALL mirror REQ-012..015 with the polarity inverted, setting d=0 on acceptance.
REQ-017 Outputs SHALL be registered; for N equal samples at edges t0..t0+N-1, d and en SHALL update after edge t0+N-1, and en SHALL drop after edge t0+N.
REQ-018 en SHALL be high for exactly one cycle per accepted change and never otherwise; d SHALL change only when en is high.
REQ-019 pending SHALL be high exactly when the state is PEND_HI or PEND_LO.
REQ-020 count SHALL increment on each en pulse and saturate at 255.
REQ-021 clear SHALL zero count; clear coincident with an acceptance SHALL give count=1.

Reset
REQ-022 Reset assertion SHALL force, asynchronously: state=STABLE_LO, cnt=0, d=0, en=0, count=0, synchronizer flops=0.
REQ-023 Reset during PEND_* SHALL abandon the candidate without an en pulse; after deassertion the first sample starts qualification afresh.

Configuration
REQ-024 With SEQ_GATES_DEBOUNCE_SYNC_EN defined, raw SHALL pass through a 2-flop synchronizer, adding exactly 2 cycles latency; without it, raw SHALL feed the FSM directly with no added latency.

Structure
REQ-025 Package seq_gates_debounce_pkg SHALL hold the FSM state enum typedef and the count width constant (8).
REQ-026 The synchronizer SHALL be sub-module seq_gates_sync2 (clk, reset, in, out), instantiated only under the REQ-024 macro.
REQ-027 An elaboration-time check SHALL reject STABLE_CYCLES outside 2..255; cnt width SHALL be $clog2(STABLE_CYCLES).

Verification (STABLE_CYCLES=4, macro undefined unless noted)
REQ-028 raw held 1 from edge 10 -> pending=1 after edge 10; d=1, en=1 after edge 13; en=0 after edge 14; count=1.
REQ-029 raw=1 for edges 10-12, then 0 -> no en, d stays 0, pending drops after edge 13.
REQ-030 reset pulsed mid-cycle while in PEND_HI -> immediately state=STABLE_LO, d=0, en=0, count=0; no strobe.
REQ-031 300 accepted toggles -> count=255 held; clear on the same edge as the 301st acceptance -> count=1.
REQ-032 Macro defined, raw held 1 from edge 10 -> d=1, en=1 after edge 15.
REQ-033 Chain to a 1b DFFE (en->en, d->d) -> DFFE q tracks d one cycle later and never glitches on 3-cycle raw pulses.
